// File: rtl/hft_pkg.sv
// Shared constants and types for the negative-cycle extraction block.
// Widths come from the Const.vh macros (`NODES, `PRED_WIDTH, `WEIGHT_WIDTH,
// `VERT_WIDTH); defaults are supplied here only when those macros are not
// already defined by the build.
`ifndef NODES
`define NODES 4
`endif
`ifndef PRED_WIDTH
`define PRED_WIDTH 1
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif
`ifndef VERT_WIDTH
`define VERT_WIDTH (`PRED_WIDTH + `WEIGHT_WIDTH + 1)
`endif

package hft_pkg;

  localparam int unsigned NODES    = `NODES;
  localparam int unsigned PRED_W   = `PRED_WIDTH + 1;
  localparam int unsigned WEIGHT_W = `WEIGHT_WIDTH + 1;
  localparam int unsigned VERT_W   = `VERT_WIDTH + 1;

  // dist value marking a vertex never reached by the relaxation pass
  localparam logic [WEIGHT_W-1:0] UNREACHED = '1;

  typedef enum logic [2:0] {
    ScanSrc,
    ScanDst,
    Check,
    Walk,
    Emit,
    Done
  } state_e;

endpackage

// File: rtl/cycle_extract.sv
// cycle_extract: after a Bellman-Ford pass, scans every edge for one that still
// relaxes, chases pred NODES times to land on the negative cycle, then streams
// the cycle's vertices over a valid/ready interface.
//
// Ports:
//   clk, cycle_reset      clock; synchronous active-high reset (deassert = start)
//   vertmat_addr/_q       vertex memory read, 1-cycle latency, q = {pred, dist}
//   adjmat_row/col_addr,  edge memory read, 1-cycle latency, signed weight,
//   adjmat_q              0 = no edge
//   cyc_vert/valid/last,  cycle vertex stream
//   cyc_ready
//   cycle_found/done      result flags, held until the next reset
//   cycle_weight          (only with CYCLE_WEIGHT_EN) sum of emitted cycle edges
module cycle_extract #(
  parameter int unsigned NODES = `NODES
) (
  input  logic                   clk,
  input  logic                   cycle_reset,
  input  logic [`VERT_WIDTH:0]   vertmat_q,
  input  logic [`WEIGHT_WIDTH:0] adjmat_q,
  output logic [`PRED_WIDTH:0]   vertmat_addr,
  output logic [`PRED_WIDTH:0]   adjmat_row_addr,
  output logic [`PRED_WIDTH:0]   adjmat_col_addr,
  output logic [`PRED_WIDTH:0]   cyc_vert,
  output logic                   cyc_valid,
  output logic                   cyc_last,
  input  logic                   cyc_ready,
  output logic                   cycle_found,
  output logic                   cycle_done
`ifdef CYCLE_WEIGHT_EN
  ,
  output logic signed [`WEIGHT_WIDTH:0] cycle_weight
`endif
);
  import hft_pkg::*;

  localparam int unsigned       CNT_W    = PRED_W + 1;
  localparam logic [PRED_W-1:0] IDX_LAST = PRED_W'(NODES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NODES - 1);

  state_e              r_state, w_state_d;
  logic [PRED_W-1:0]   r_i, w_i_d, r_j, w_j_d, r_v, w_v_d, r_start, w_start_d;
  logic [PRED_W-1:0]   r_pred, w_pred_d, r_vaddr, w_vaddr_d;
  logic [PRED_W-1:0]   r_row, w_row_d, r_col, w_col_d, r_cyc_vert, w_cyc_vert_d;
  logic [WEIGHT_W-1:0] r_dist_i, w_dist_i_d, r_edge, w_edge_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_phase, w_phase_d, r_found, w_found_d;
  logic                r_cyc_valid, w_cyc_valid_d, r_cyc_last, w_cyc_last_d;
  logic [PRED_W-1:0]   w_q_pred;
  logic [WEIGHT_W-1:0] w_q_dist, w_sum;
  logic                w_hit;
`ifdef CYCLE_WEIGHT_EN
  logic [WEIGHT_W-1:0] r_weight, w_weight_d;
  // Edge weight arrives two cycles after its address is chosen.
  logic [1:0]          r_acc_sh, w_acc_sh_d;
`endif

  assign w_q_pred = vertmat_q[VERT_W-1 -: PRED_W];
  assign w_q_dist = vertmat_q[WEIGHT_W-1:0];
  // Wrapping add; the compare is signed on the wrapped result.
  assign w_sum    = r_dist_i + r_edge;
  assign w_hit    = (r_edge != '0) && (r_dist_i != UNREACHED) &&
                    ($signed(w_sum) < $signed(w_q_dist));

  always_comb begin
    w_state_d     = r_state;
    w_i_d         = r_i;
    w_j_d         = r_j;
    w_v_d         = r_v;
    w_start_d     = r_start;
    w_pred_d      = r_pred;
    w_vaddr_d     = r_vaddr;
    w_row_d       = r_row;
    w_col_d       = r_col;
    w_cyc_vert_d  = r_cyc_vert;
    w_dist_i_d    = r_dist_i;
    w_edge_d      = r_edge;
    w_cnt_d       = r_cnt;
    w_phase_d     = r_phase;
    w_found_d     = r_found;
    w_cyc_valid_d = r_cyc_valid;
    w_cyc_last_d  = r_cyc_last;
`ifdef CYCLE_WEIGHT_EN
    w_acc_sh_d    = {r_acc_sh[0], 1'b0};
    w_weight_d    = r_acc_sh[1] ? r_weight + adjmat_q : r_weight;
`endif
    unique case (r_state)
      // vertmat_addr = i and adjmat addr = (i,j) are presented here.
      ScanSrc: begin
        w_vaddr_d = r_j;
        w_state_d = ScanDst;
      end
      ScanDst: begin
        w_dist_i_d = w_q_dist;
        w_edge_d   = adjmat_q;
        w_state_d  = Check;
      end
      // vertmat_q now holds dist[j].
      Check: begin
        if (w_hit) begin
          w_v_d     = r_j;
          w_vaddr_d = r_j;
          w_cnt_d   = '0;
          w_phase_d = 1'b0;
          w_state_d = Walk;
        end else if (r_j == IDX_LAST) begin
          if (r_i == IDX_LAST) begin
            w_state_d = Done;
          end else begin
            w_i_d     = r_i + PRED_W'(1);
            w_j_d     = '0;
            w_vaddr_d = r_i + PRED_W'(1);
            w_row_d   = r_i + PRED_W'(1);
            w_col_d   = '0;
            w_state_d = ScanSrc;
          end
        end else begin
          w_j_d     = r_j + PRED_W'(1);
          w_vaddr_d = r_i;
          w_col_d   = r_j + PRED_W'(1);
          w_state_d = ScanSrc;
        end
      end
      // Phase 0 presents v, phase 1 consumes pred[v].
      Walk: begin
        if (!r_phase) begin
          w_phase_d = 1'b1;
        end else begin
          w_phase_d = 1'b0;
          w_v_d     = w_q_pred;
          w_vaddr_d = w_q_pred;
          w_cnt_d   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_start_d = w_q_pred;
            w_cnt_d   = '0;
            w_state_d = Emit;
          end
        end
      end
      // pred[v] is fetched before the beat is raised so cyc_last is known.
      Emit: begin
        if (r_cyc_valid) begin
          if (cyc_ready) begin
            w_cyc_valid_d = 1'b0;
            if (r_cyc_last) begin
              w_found_d = 1'b1;
              w_state_d = Done;
            end else begin
              w_v_d     = r_pred;
              w_vaddr_d = r_pred;
              w_cnt_d   = r_cnt + CNT_W'(1);
            end
          end
        end else if (!r_phase) begin
          w_phase_d = 1'b1;
        end else begin
          w_phase_d     = 1'b0;
          w_pred_d      = w_q_pred;
          w_cyc_valid_d = 1'b1;
          w_cyc_vert_d  = r_v;
          w_cyc_last_d  = (w_q_pred == r_start) || (r_cnt == CNT_LAST);
`ifdef CYCLE_WEIGHT_EN
          w_row_d       = w_q_pred;
          w_col_d       = r_v;
          w_acc_sh_d[0] = 1'b1;
`endif
        end
      end
      Done: begin
        w_state_d = Done;
      end
      default: begin
        w_state_d = ScanSrc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (cycle_reset) begin
      r_state     <= ScanSrc;
      r_i         <= '0;
      r_j         <= '0;
      r_v         <= '0;
      r_start     <= '0;
      r_pred      <= '0;
      r_vaddr     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_cyc_vert  <= '0;
      r_dist_i    <= '0;
      r_edge      <= '0;
      r_cnt       <= '0;
      r_phase     <= 1'b0;
      r_found     <= 1'b0;
      r_cyc_valid <= 1'b0;
      r_cyc_last  <= 1'b0;
`ifdef CYCLE_WEIGHT_EN
      r_weight    <= '0;
      r_acc_sh    <= '0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_i         <= w_i_d;
      r_j         <= w_j_d;
      r_v         <= w_v_d;
      r_start     <= w_start_d;
      r_pred      <= w_pred_d;
      r_vaddr     <= w_vaddr_d;
      r_row       <= w_row_d;
      r_col       <= w_col_d;
      r_cyc_vert  <= w_cyc_vert_d;
      r_dist_i    <= w_dist_i_d;
      r_edge      <= w_edge_d;
      r_cnt       <= w_cnt_d;
      r_phase     <= w_phase_d;
      r_found     <= w_found_d;
      r_cyc_valid <= w_cyc_valid_d;
      r_cyc_last  <= w_cyc_last_d;
`ifdef CYCLE_WEIGHT_EN
      r_weight    <= w_weight_d;
      r_acc_sh    <= w_acc_sh_d;
`endif
    end
  end

  assign vertmat_addr    = r_vaddr;
  assign adjmat_row_addr = r_row;
  assign adjmat_col_addr = r_col;
  assign cyc_vert        = r_cyc_vert;
  assign cyc_valid       = r_cyc_valid;
  assign cyc_last        = r_cyc_last;
  assign cycle_found     = r_found;
`ifdef CYCLE_WEIGHT_EN
  // Done is only reported once the last edge weight has been summed.
  assign cycle_done      = (r_state == Done) && (r_acc_sh == 2'b00);
  assign cycle_weight    = r_weight;
`else
  assign cycle_done      = (r_state == Done);
`endif

endmodule

// File: tb/tb_cycle_extract.sv
module tb_cycle_extract;
  import hft_pkg::*;

  localparam int N  = NODES;
  localparam int PW = PRED_W;
  localparam int WW = WEIGHT_W;

  logic          clk = 1'b0;
  logic          cycle_reset = 1'b1;
  logic [VERT_W-1:0] vertmat_q = '0;
  logic [WW-1:0] adjmat_q = '0;
  logic [PW-1:0] vertmat_addr, adjmat_row_addr, adjmat_col_addr, cyc_vert;
  logic          cyc_valid, cyc_last, cycle_found, cycle_done;
  logic          cyc_ready = 1'b0;
`ifdef CYCLE_WEIGHT_EN
  logic [WW-1:0] cycle_weight;
`endif

  cycle_extract #(.NODES(N)) dut (
    .clk             (clk),
    .cycle_reset     (cycle_reset),
    .vertmat_q       (vertmat_q),
    .adjmat_q        (adjmat_q),
    .vertmat_addr    (vertmat_addr),
    .adjmat_row_addr (adjmat_row_addr),
    .adjmat_col_addr (adjmat_col_addr),
    .cyc_vert        (cyc_vert),
    .cyc_valid       (cyc_valid),
    .cyc_last        (cyc_last),
    .cyc_ready       (cyc_ready),
    .cycle_found     (cycle_found),
    .cycle_done      (cycle_done)
`ifdef CYCLE_WEIGHT_EN
    ,
    .cycle_weight    (cycle_weight)
`endif
  );

  always #5 clk = ~clk;

  // Graph memories with one-cycle read latency.
  logic [PW-1:0] m_pred [N];
  logic [WW-1:0] m_dist [N];
  logic [WW-1:0] m_adj  [N][N];

  always @(posedge clk) begin
    vertmat_q <= {m_pred[vertmat_addr], m_dist[vertmat_addr]};
    adjmat_q  <= m_adj[adjmat_row_addr][adjmat_col_addr];
  end

  typedef struct packed {
    logic [PW-1:0] vert;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            beats_acc = 0;
  int            exp_beats = 0;
  bit            exp_found = 0;
  bit            valid_seen = 0;
  bit            hold_req = 0;
  logic [WW-1:0] exp_weight = '0;
  string         cur = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d, expected %0d", cur, name, act, exp);
    end
  endtask

  // Reference model: first improving edge in row-major order, walk N preds,
  // then follow pred from there until it returns to the start.
  task automatic build_expect();
    int            hi = -1;
    int            hj = -1;
    int            v;
    int            st;
    logic [WW-1:0] s;
    exp_q.delete();
    exp_found  = 0;
    exp_weight = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = m_dist[i] + m_adj[i][j];
        if (hi < 0 && m_adj[i][j] != '0 && m_dist[i] != {WW{1'b1}} &&
            $signed(s) < $signed(m_dist[j])) begin
          hi = i;
          hj = j;
        end
      end
    end
    if (hi >= 0) begin
      exp_found = 1;
      v = hj;
      repeat (N) v = int'(m_pred[v]);
      st = v;
      for (int k = 0; k < N; k++) begin
        bit last;
        last = (int'(m_pred[v]) == st) || (k == N - 1);
        exp_q.push_back('{vert: PW'(v), last: last});
        exp_weight += m_adj[m_pred[v]][v];
        v = int'(m_pred[v]);
        if (last) break;
      end
    end
    exp_beats = exp_q.size();
  endtask

  task automatic clear_graph();
    for (int i = 0; i < N; i++) begin
      m_pred[i] = PW'(i);
      m_dist[i] = '0;
      for (int j = 0; j < N; j++) m_adj[i][j] = '0;
    end
  endtask

  task automatic ready_proc();
    forever begin
      @(posedge clk);
      #1;
      if (hold_req && beats_acc == 1) begin
        hold_req  = 0;
        cyc_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
      end
      cyc_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic monitor_proc();
    bit            p_valid = 0;
    bit            p_acc = 0;
    logic [PW-1:0] p_vert = '0;
    logic          p_last = 1'b0;
    beat_t         b;
    forever begin
      @(negedge clk);
      if (p_valid && !p_acc) begin
        check("hold_valid", 32'(cyc_valid), 32'd1);
        check("hold_vert", 32'(cyc_vert), 32'(p_vert));
        check("hold_last", 32'(cyc_last), 32'(p_last));
      end
      if (cyc_valid && !cycle_reset) valid_seen = 1;
      if (cyc_valid && cyc_ready && !cycle_reset) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          b = exp_q.pop_front();
          check("beat_vert", 32'(cyc_vert), 32'(b.vert));
          check("beat_last", 32'(cyc_last), 32'(b.last));
        end
        beats_acc++;
      end
      p_valid = cyc_valid && !cycle_reset;
      p_acc   = cyc_valid && cyc_ready;
      p_vert  = cyc_vert;
      p_last  = cyc_last;
    end
  endtask

  task automatic start_run();
    cycle_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    build_expect();
    beats_acc  = 0;
    valid_seen = 0;
    cycle_reset = 1'b0;
  endtask

  task automatic finish_run();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (cycle_done) break;
    end
    check("done", 32'(cycle_done), 32'd1);
    check("found", 32'(cycle_found), 32'(exp_found));
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("beats_taken", 32'(beats_acc), 32'(exp_beats));
    check("valid_seen", 32'(valid_seen), 32'(exp_beats != 0));
`ifdef CYCLE_WEIGHT_EN
    check("weight", 32'(cycle_weight), 32'(exp_weight));
`endif
    repeat (3) @(negedge clk);
    check("done_hold", 32'(cycle_done), 32'd1);
    check("valid_low", 32'(cyc_valid), 32'd0);
  endtask

  task automatic run_case(input string nm, input bit hold);
    cur      = nm;
    start_run();
    hold_req = hold;
    finish_run();
  endtask

  task automatic main_proc();
    clear_graph();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(cyc_valid), 32'd0);
    check("rst_last", 32'(cyc_last), 32'd0);
    check("rst_vert", 32'(cyc_vert), 32'd0);
    check("rst_found", 32'(cycle_found), 32'd0);
    check("rst_done", 32'(cycle_done), 32'd0);
    check("rst_addr", 32'({vertmat_addr, adjmat_row_addr, adjmat_col_addr}), 32'd0);

    // Single improving edge 1->2 on a prepared pred ring.
    clear_graph();
    m_dist[0] = WW'(0); m_dist[1] = WW'(5); m_dist[2] = WW'(3); m_dist[3] = WW'(2);
    m_adj[1][2] = WW'(-4);
    m_pred[0] = PW'(1); m_pred[1] = PW'(2); m_pred[2] = PW'(3); m_pred[3] = PW'(0);
    run_case("edge12", 0);

    // Four-edge cycle closed by 2->3 = -9: stream 3,2,1,0.
    clear_graph();
    m_pred[0] = PW'(3); m_pred[1] = PW'(0); m_pred[2] = PW'(1); m_pred[3] = PW'(2);
    m_dist[0] = WW'(0); m_dist[1] = WW'(1); m_dist[2] = WW'(2); m_dist[3] = WW'(2);
    m_adj[3][0] = WW'(1); m_adj[0][1] = WW'(1); m_adj[1][2] = WW'(1); m_adj[2][3] = WW'(-9);
    run_case("ring4", 0);
    run_case("ring4_hold", 1);

    // All distances already minimal.
    clear_graph();
    m_dist[1] = WW'(1); m_dist[2] = WW'(2); m_dist[3] = WW'(3);
    m_adj[0][1] = WW'(1); m_adj[1][2] = WW'(1); m_adj[2][3] = WW'(1);
    run_case("nocycle", 0);

    // Unreached source must not relax.
    clear_graph();
    m_dist[1] = '1; m_dist[2] = WW'(5); m_dist[3] = WW'(5);
    m_adj[1][0] = WW'(-100);
    run_case("unreached", 0);

    // Wrapping sum: max positive + 1 becomes most negative.
    clear_graph();
    m_dist[0] = {1'b0, {(WW-1){1'b1}}};
    m_adj[0][1] = WW'(1);
    m_pred[1] = PW'(0); m_pred[0] = PW'(1);
    run_case("wrap", 0);

    // Reset during EMIT, then identical rerun.
    clear_graph();
    m_pred[0] = PW'(3); m_pred[1] = PW'(0); m_pred[2] = PW'(1); m_pred[3] = PW'(2);
    m_dist[0] = WW'(0); m_dist[1] = WW'(1); m_dist[2] = WW'(2); m_dist[3] = WW'(2);
    m_adj[3][0] = WW'(1); m_adj[0][1] = WW'(1); m_adj[1][2] = WW'(1); m_adj[2][3] = WW'(-9);
    cur = "midreset";
    start_run();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cyc_valid && beats_acc >= 2) break;
    end
    check("pre_valid", 32'(cyc_valid), 32'd1);
    @(posedge clk);
    #1;
    cycle_reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_valid", 32'(cyc_valid), 32'd0);
    check("abort_done", 32'(cycle_done), 32'd0);
    start_run();
    finish_run();

    // Random graphs.
    for (int r = 0; r < 6; r++) begin
      clear_graph();
      for (int i = 0; i < N; i++) begin
        m_pred[i] = PW'($urandom_range(0, N - 1));
        m_dist[i] = ($urandom_range(0, 7) == 0) ? '1 : WW'($urandom_range(0, 20));
        for (int j = 0; j < N; j++)
          if ($urandom_range(0, 2) == 0) m_adj[i][j] = WW'(int'($urandom_range(0, 20)) - 10);
      end
      run_case($sformatf("rand%0d", r), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    fork
      ready_proc();
      monitor_proc();
      main_proc();
    join_any
  end

endmodule
